// File: rtl/pixel_seq_ctrl.sv
// pixel_seq_ctrl: parametrised pixel-array phase sequencer.
// Drives erase -> expose -> convert -> per-row read strobes for one frame,
// with a programmable exposure length (shadow register copied at the start of
// each exposure), single-shot or continuous frames, and a convert ramp count.
// Optional feature macro: PIXEL_SEQ_ABORT_EN adds an 'abort' input that
// returns a running frame to IDLE without a frame_done pulse.
// All outputs are registered; reset is synchronous and active-high.

module pixel_seq_ctrl #(
  parameter int CNT_W          = 8,
  parameter int N_ROWS         = 2,
  parameter int C_ERASE        = 5,
  parameter int C_CONVERT      = 255,
  parameter int C_READ         = 5,
  parameter int DEFAULT_EXPOSE = 255,
  localparam int ROW_W         = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  expose_cfg,
`ifdef PIXEL_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [N_ROWS-1:0] read,
  output logic [ROW_W-1:0]  row_idx,
  output logic [CNT_W-1:0]  conv_count,
  output logic              busy,
  output logic              frame_done
);

  // Last counter value of each fixed-length phase
  localparam logic [CNT_W-1:0] ERASE_LAST   = CNT_W'(C_ERASE - 1);
  localparam logic [CNT_W-1:0] CONVERT_LAST = CNT_W'(C_CONVERT - 1);
  localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(C_READ - 1);
  localparam logic [CNT_W-1:0] EXPOSE_RST   = CNT_W'(DEFAULT_EXPOSE);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  // One-hot decode of the row index into the read strobe vector
  function automatic logic [N_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
    logic [N_ROWS-1:0] v;
    for (int i = 0; i < N_ROWS; i++) begin
      v[i] = (r == ROW_W'(i));
    end
    return v;
  endfunction

  // A programmed exposure of 0 is run as a single cycle
  function automatic logic [CNT_W-1:0] clamp_expose(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b0}}) ? CNT_W'(1) : v;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [ROW_W-1:0]  row_r;
  logic [ROW_W-1:0]  row_nxt_s;
  logic [CNT_W-1:0]  shadow_r;
  logic [CNT_W-1:0]  exp_len_r;
  logic              phase_last_s;
  logic              frame_end_s;
  logic              abort_s;

  logic              erase_nxt_s;
  logic              expose_nxt_s;
  logic              convert_nxt_s;
  logic [N_ROWS-1:0] read_nxt_s;
  logic [ROW_W-1:0]  row_idx_nxt_s;
  logic [CNT_W-1:0]  conv_count_nxt_s;
  logic              busy_nxt_s;
  logic              frame_done_nxt_s;

`ifdef PIXEL_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // State, phase counter and row register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      row_r   <= {ROW_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      row_r   <= row_nxt_s;
    end
  end

  // Shadow exposure register; written by cfg_load in any state
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= EXPOSE_RST;
    end else if (cfg_load) begin
      shadow_r <= expose_cfg;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active exposure length; captured from the (old) shadow as EXPOSE begins
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_len_r <= clamp_expose(EXPOSE_RST);
    end else if ((state_r == ST_ERASE) && (state_nxt_s == ST_EXPOSE)) begin
      exp_len_r <= clamp_expose(shadow_r);
    end else begin
      exp_len_r <= exp_len_r;
    end
  end

  // Detect the last cycle of the current phase
  always_comb begin
    phase_last_s = 1'b0;
    case (state_r)
      ST_ERASE:   phase_last_s = (cnt_r == ERASE_LAST);
      ST_EXPOSE:  phase_last_s = (cnt_r == (exp_len_r - CNT_W'(1)));
      ST_CONVERT: phase_last_s = (cnt_r == CONVERT_LAST);
      ST_READ:    phase_last_s = (cnt_r == READ_LAST);
      default:    phase_last_s = 1'b0;
    endcase
  end

  // Next state, next row and next phase counter
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        row_nxt_s = {ROW_W{1'b0}};
        if (start) begin
          state_nxt_s = ST_ERASE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (phase_last_s) begin
          state_nxt_s = ST_EXPOSE;
        end else begin
          state_nxt_s = ST_ERASE;
        end
      end
      ST_EXPOSE: begin
        if (phase_last_s) begin
          state_nxt_s = ST_CONVERT;
        end else begin
          state_nxt_s = ST_EXPOSE;
        end
      end
      ST_CONVERT: begin
        if (phase_last_s) begin
          state_nxt_s = ST_READ;
          row_nxt_s   = {ROW_W{1'b0}};
        end else begin
          state_nxt_s = ST_CONVERT;
        end
      end
      ST_READ: begin
        if (phase_last_s && (row_r == ROW_LAST)) begin
          frame_end_s = 1'b1;
          row_nxt_s   = {ROW_W{1'b0}};
          if (continuous) begin
            state_nxt_s = ST_ERASE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (phase_last_s) begin
          row_nxt_s = row_r + ROW_W'(1);
        end else begin
          row_nxt_s = row_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        row_nxt_s   = {ROW_W{1'b0}};
      end
    endcase

    // Abort overrides every transition including the end of frame
    if (abort_s && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
      row_nxt_s   = {ROW_W{1'b0}};
      frame_end_s = 1'b0;
    end else begin
      frame_end_s = frame_end_s;
    end

    // Counter restarts whenever the phase (state or row) changes
    if ((state_nxt_s == ST_IDLE) || (state_nxt_s != state_r) || (row_nxt_s != row_r)) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    erase_nxt_s      = 1'b0;
    expose_nxt_s     = 1'b0;
    convert_nxt_s    = 1'b0;
    read_nxt_s       = {N_ROWS{1'b0}};
    row_idx_nxt_s    = {ROW_W{1'b0}};
    conv_count_nxt_s = {CNT_W{1'b0}};
    busy_nxt_s       = (state_nxt_s != ST_IDLE);
    frame_done_nxt_s = frame_end_s;
    case (state_nxt_s)
      ST_ERASE:   erase_nxt_s = 1'b1;
      ST_EXPOSE:  expose_nxt_s = 1'b1;
      ST_CONVERT: begin
        convert_nxt_s    = 1'b1;
        conv_count_nxt_s = cnt_nxt_s;
      end
      ST_READ: begin
        read_nxt_s    = row_onehot(row_nxt_s);
        row_idx_nxt_s = row_nxt_s;
      end
      default: begin
        erase_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= {N_ROWS{1'b0}};
      row_idx    <= {ROW_W{1'b0}};
      conv_count <= {CNT_W{1'b0}};
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      erase      <= erase_nxt_s;
      expose     <= expose_nxt_s;
      convert    <= convert_nxt_s;
      read       <= read_nxt_s;
      row_idx    <= row_idx_nxt_s;
      conv_count <= conv_count_nxt_s;
      busy       <= busy_nxt_s;
      frame_done <= frame_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed, table-driven bench for pixel_seq_ctrl at default parameters.
// Cycle n = the n-th cycle after the clock edge that samples start=1;
// outputs are observed on the falling edge inside that cycle.

module tb_pixel_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       continuous;
  logic       cfg_load;
  logic [7:0] expose_cfg;
  logic       abort;
  logic       erase;
  logic       expose;
  logic       convert;
  logic [1:0] read;
  logic [0:0] row_idx;
  logic [7:0] conv_count;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[14];

  pixel_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .cfg_load   (cfg_load),
    .expose_cfg (expose_cfg),
`ifdef PIXEL_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read       (read),
    .row_idx    (row_idx),
    .conv_count (conv_count),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic e, input logic x, input logic c,
                                     input logic [1:0] rd, input logic row,
                                     input logic [7:0] cv, input logic b, input logic d);
    return {e, x, c, rd, row, cv, b, d};
  endfunction

  function automatic logic [15:0] obs();
    return {erase, expose, convert, read, row_idx, conv_count, busy, frame_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance to the observation point of cycle n
  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Pulse start so it is sampled at edge 0
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
  endtask

  task automatic cfg_write(input logic [7:0] v);
    @(negedge clk);
    cfg_load   = 1'b1;
    expose_cfg = v;
    @(negedge clk);
    cfg_load   = 1'b0;
  endtask

  int busy_bad;
  logic [15:0] zero_v;

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; cfg_load = 1'b0;
    expose_cfg = 8'd0; abort = 1'b0;
    zero_v = 16'd0;

    //                  erase  expose convert read  row   conv    busy  done
    tbl[0]  = '{1,   mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[1]  = '{5,   mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[2]  = '{6,   mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[3]  = '{260, mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[4]  = '{261, mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[5]  = '{262, mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd1,   1'b1, 1'b0)};
    tbl[6]  = '{515, mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'd254, 1'b1, 1'b0)};
    tbl[7]  = '{516, mk(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[8]  = '{520, mk(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'd0,   1'b1, 1'b0)};
    tbl[9]  = '{521, mk(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 8'd0,   1'b1, 1'b0)};
    tbl[10] = '{525, mk(1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 8'd0,   1'b1, 1'b0)};
    tbl[11] = '{526, mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0,   1'b0, 1'b1)};
    tbl[12] = '{527, mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0,   1'b0, 1'b0)};
    tbl[13] = '{540, mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0,   1'b0, 1'b0)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", {16'd0, obs()}, {16'd0, zero_v});
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {16'd0, obs()}, {16'd0, zero_v});

    // Frame 1: default exposure, single shot, table-driven
    start_frame();
    for (int i = 0; i < 14; i++) begin
      goto(tbl[i].cyc);
      chk($sformatf("frame1_c%0d", tbl[i].cyc), {16'd0, obs()}, {16'd0, tbl[i].exp});
    end

    // Exposure of 10 loaded in IDLE
    cfg_write(8'd10);
    start_frame();
    goto(6);   chk("exp10_c6",   {16'd0, obs()}, {16'd0, mk(1'b0,1'b1,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(15);  chk("exp10_c15",  {16'd0, obs()}, {16'd0, mk(1'b0,1'b1,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(16);  chk("exp10_c16",  {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b1,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(280); chk("exp10_c280", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b10,1'b1,8'd0,1'b1,1'b0)});
    goto(281); chk("exp10_c281", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b00,1'b0,8'd0,1'b0,1'b1)});
    goto(290);

    // Continuous: two back-to-back frames with default exposure
    cfg_write(8'd255);
    continuous = 1'b1;
    start_frame();
    busy_bad = 0;
    for (int c = 1; c <= 1051; c++) begin
      goto(c);
      if (c <= 1050 && busy !== 1'b1) busy_bad++;
      if (c == 526)
        chk("cont_c526", {16'd0, obs()}, {16'd0, mk(1'b1,1'b0,1'b0,2'b00,1'b0,8'd0,1'b1,1'b1)});
      if (c == 600) continuous = 1'b0;
      if (c == 1050)
        chk("cont_c1050", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b10,1'b1,8'd0,1'b1,1'b0)});
    end
    chk("cont_busy_held", busy_bad, 0);
    chk("cont_c1051", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b00,1'b0,8'd0,1'b0,1'b1)});
    goto(1052); chk("cont_c1052", {16'd0, obs()}, {16'd0, zero_v});

    // cfg_load of 0 mid-exposure: current frame unchanged, next frame 1 cycle
    continuous = 1'b1;
    start_frame();
    goto(100); cfg_load = 1'b1; expose_cfg = 8'd0;
    goto(101); cfg_load = 1'b0;
    goto(260); chk("cfg0_c260", {16'd0, obs()}, {16'd0, mk(1'b0,1'b1,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(261); chk("cfg0_c261", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b1,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(526); chk("cfg0_c526", {16'd0, obs()}, {16'd0, mk(1'b1,1'b0,1'b0,2'b00,1'b0,8'd0,1'b1,1'b1)});
    goto(527); continuous = 1'b0;
    goto(530); chk("cfg0_c530", {16'd0, obs()}, {16'd0, mk(1'b1,1'b0,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(531); chk("cfg0_c531", {16'd0, obs()}, {16'd0, mk(1'b0,1'b1,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(532); chk("cfg0_c532", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b1,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(786); chk("cfg0_c786", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b1,2'b00,1'b0,8'd254,1'b1,1'b0)});
    goto(787); chk("cfg0_c787", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b01,1'b0,8'd0,1'b1,1'b0)});
    goto(797); chk("cfg0_c797", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b00,1'b0,8'd0,1'b0,1'b1)});
    goto(800);

    // start ignored mid-frame, then reset during CONVERT
    cfg_write(8'd255);
    start_frame();
    goto(200); start = 1'b1;
    goto(201); start = 1'b0;
    chk("ign_start_c201", {16'd0, obs()}, {16'd0, mk(1'b0,1'b1,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(300); reset = 1'b1;
    goto(301); reset = 1'b0;
    chk("rst_mid_c301", {16'd0, obs()}, {16'd0, zero_v});
    goto(302); chk("rst_mid_c302", {16'd0, obs()}, {16'd0, zero_v});
    goto(530); chk("rst_mid_c530", {16'd0, obs()}, {16'd0, zero_v});

`ifdef PIXEL_SEQ_ABORT_EN
    // Abort during row 0 read, then a complete frame
    start_frame();
    goto(518); chk("abort_c518", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b01,1'b0,8'd0,1'b1,1'b0)});
    abort = 1'b1;
    goto(519); abort = 1'b0;
    chk("abort_c519", {16'd0, obs()}, {16'd0, zero_v});
    goto(526); chk("abort_c526", {16'd0, obs()}, {16'd0, zero_v});
    start_frame();
    goto(1);   chk("post_abort_c1",   {16'd0, obs()}, {16'd0, mk(1'b1,1'b0,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(260); chk("post_abort_c260", {16'd0, obs()}, {16'd0, mk(1'b0,1'b1,1'b0,2'b00,1'b0,8'd0,1'b1,1'b0)});
    goto(525); chk("post_abort_c525", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b10,1'b1,8'd0,1'b1,1'b0)});
    goto(526); chk("post_abort_c526", {16'd0, obs()}, {16'd0, mk(1'b0,1'b0,1'b0,2'b00,1'b0,8'd0,1'b0,1'b1)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
